cnn_conv_sequencer: RTL

CNN_CONV_SEQUENCER -- requirements
Module: cnn_conv_sequencer

---
 rtl/cnn_conv_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cnn_conv_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_conv_sequencer
//
// Walks a 3x3 kernel across a square binary image in raster order. For each
// output-map position it presents one registered window sum on a
// valid/ready stream. A frame starts from IDLE on start=1. At that moment the
// image and the kernel are copied, so later input changes cannot disturb
// the frame.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   start      frame request, honoured only in IDLE
//   image      IMG_DIM*IMG_DIM binary pixels, pixel(r,c) = image[r*IMG_DIM+c]
//   kernel     nine unsigned 8-bit weights, w(i,j) = kernel[(i*3+j)*8 +: 8]
//   out_ready  downstream accepts the current result
//   out_valid  out_data/out_row/out_col hold a result
//   out_data   12-bit window sum (max 9*255 = 2295)
//   out_row    output-map row of the current result
//   out_col    output-map column of the current result
//   busy       high in RUN and DONE
//   done       one-cycle pulse after the last transfer
// ---------------------------------------------------------------------------
module cnn_conv_sequencer #(
  parameter int IMG_DIM = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [IMG_DIM*IMG_DIM-1:0]   image,
  input  logic [71:0]                  kernel,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [11:0]                  out_data,
  output logic [$clog2(IMG_DIM)-1:0]   out_row,
  output logic [$clog2(IMG_DIM)-1:0]   out_col,
  output logic                         busy,
  output logic                         done
);

  localparam int NPIX = IMG_DIM * IMG_DIM;
  localparam int CW   = $clog2(IMG_DIM);
  localparam int IW   = $clog2(NPIX);
  localparam logic [CW-1:0] LAST = CW'(IMG_DIM - 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [NPIX-1:0]   img_q, img_d;
  logic [71:0]       ker_q, ker_d;
  logic [CW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [11:0]       data_q, data_d;

  // Sum of the weights whose pixel is set in the 3x3 window at (r,c).
  function automatic logic [11:0] window_sum(
    input logic [NPIX-1:0] img,
    input logic [71:0]     ker,
    input logic [CW-1:0]   r,
    input logic [CW-1:0]   c
  );
    logic [11:0]   acc;
    logic [IW-1:0] pidx;
    logic [6:0]    kidx;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        pidx = IW'((int'(r) + i) * IMG_DIM + int'(c) + j);
        kidx = 7'((i * 3 + j) * 8);
        if (img[pidx]) acc = acc + {4'd0, ker[kidx +: 8]};
      end
    end
    return acc;
  endfunction

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    img_d   = img_q;
    ker_d   = ker_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          img_d   = image;
          ker_d   = kernel;
          row_d   = '0;
          col_d   = '0;
          // The copies are not loaded yet, so the first sum uses the live inputs.
          data_d  = window_sum(image, kernel, '0, '0);
        end
      end
      S_RUN: begin
        if (out_ready) begin
          if (row_q == LAST && col_q == LAST) begin
            state_d = S_DONE;
          end else begin
            if (col_q == LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            // NOTE: blocking assignments here, so row_d/col_d above are already
            // the advanced position when the next sum is computed.
            data_d = window_sum(img_q, ker_q, row_d, col_d);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

  // NOTE: the image/kernel copies are plain data storage loaded on every start
  // before use, so they carry no reset.
  always_ff @(posedge clk) begin
    img_q <= img_d;
    ker_q <= ker_d;
  end

  assign out_valid = (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_data  = data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;

endmodule
